// File: rtl/game_pkg.sv
// game_pkg: shared types for the game-flow controller.
//  state_t   - game-flow FSM states
//  menu_id_t - overlay screen select driven to the menu renderer
//  menu_of() - maps an FSM state to the overlay screen it shows
package game_pkg;

  typedef enum logic [2:0] {
    S_MENU      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_PLAY      = 3'd2,
    S_PAUSE     = 3'd3,
    S_OVER      = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    MENU_NONE  = 2'd0,
    MENU_MAIN  = 2'd1,
    MENU_PAUSE = 2'd2,
    MENU_OVER  = 2'd3
  } menu_id_t;

  function automatic menu_id_t menu_of(input state_t s);
    case (s)
      S_MENU:  return MENU_MAIN;
      S_PAUSE: return MENU_PAUSE;
      S_OVER:  return MENU_OVER;
      default: return MENU_NONE;   // countdown and play draw no menu
    endcase
  endfunction

endpackage

// File: rtl/game_state_ctrl_frame_tick_gen.sv
// frame_tick_gen: rising-edge detector on vblnk, producing a one-clk frame tick.
//  clk   in  pixel clock
//  rst   in  synchronous active-high reset
//  vblnk in  vertical blank from the timing chain
//  tick  out high for the single clk in which vblnk has just risen
// vblnk_d resets to 1 so a vblnk that is already high when reset releases
// does not look like a fresh frame start.
module frame_tick_gen (
  input  logic clk,
  input  logic rst,
  input  logic vblnk,
  output logic tick
);

  logic vblnk_d;

  always_ff @(posedge clk) begin
    if (rst) vblnk_d <= 1'b1;
    else     vblnk_d <= vblnk;
  end

  assign tick = vblnk & ~vblnk_d;

endmodule

// File: rtl/game_state_ctrl.sv
// game_state_ctrl: game-flow FSM for the menu overlay and game logic.
//  clk        in   pixel clock
//  rst        in   synchronous active-high reset
//  vblnk      in   vertical blank; rising edge = frame tick
//  start      in   one-clk start/resume request
//  pause      in   one-clk pause toggle request
//  game_over  in   one-clk game-over event from game logic
//  is_game_on out  1 only while playing
//  menu_id    out  overlay screen select (menu_id_t encoding)
//  countdown  out  countdown digit during the start countdown, else 0
//  game_reset out  one-clk pulse clearing game state before a new game
// Every state change is committed in a tick cycle so the overlay never
// switches mid-frame; between ticks requests are only remembered.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int COUNTDOWN_START  = 3,
  parameter int COUNTDOWN_FRAMES = 60,
  parameter int OVER_HOLD_FRAMES = 180
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vblnk,
  input  logic       start,
  input  logic       pause,
  input  logic       game_over,
  output logic       is_game_on,
  output logic [1:0] menu_id,
  output logic [1:0] countdown,
  output logic       game_reset
);

  localparam int FMAX = (COUNTDOWN_FRAMES > OVER_HOLD_FRAMES) ? COUNTDOWN_FRAMES
                                                              : OVER_HOLD_FRAMES;
  localparam int FCW  = $clog2(FMAX + 1);

  localparam logic [FCW-1:0] CD_LAST   = FCW'(COUNTDOWN_FRAMES - 1);
  localparam logic [FCW-1:0] OVER_LAST = FCW'(OVER_HOLD_FRAMES - 1);
  localparam logic [1:0]     CD_FIRST  = 2'(COUNTDOWN_START);

  logic tick;

  frame_tick_gen u_tick (
    .clk   (clk),
    .rst   (rst),
    .vblnk (vblnk),
    .tick  (tick)
  );

  // Sticky requests. A pulse landing in the tick cycle itself is seen
  // directly through the ev_* terms; all flags drop at every tick whether
  // the request was acted on or not.
  logic pend_start, pend_pause, pend_over;
  logic ev_start, ev_pause, ev_over;

  assign ev_start = pend_start | start;
  assign ev_pause = pend_pause | pause;
  assign ev_over  = pend_over  | game_over;

  always_ff @(posedge clk) begin
    if (rst || tick) begin
      pend_start <= 1'b0;
      pend_pause <= 1'b0;
      pend_over  <= 1'b0;
    end else begin
      pend_start <= pend_start | start;
      pend_pause <= pend_pause | pause;
      pend_over  <= pend_over  | game_over;
    end
  end

  state_t         state, nxt_state;
  logic [FCW-1:0] fcnt,  nxt_fcnt;
  logic [1:0]     digit, nxt_digit;
  logic           new_game;

  always_comb begin
    nxt_state = state;
    nxt_fcnt  = fcnt;
    nxt_digit = digit;
    new_game  = 1'b0;
    if (tick) begin
      case (state)
        S_MENU: begin
          if (ev_start) begin
            nxt_state = S_COUNTDOWN;
            nxt_digit = CD_FIRST;
            nxt_fcnt  = '0;
            new_game  = 1'b1;
          end
        end
        S_COUNTDOWN: begin
          if (fcnt == CD_LAST) begin
            nxt_fcnt = '0;
            if (digit == 2'd1) begin
              nxt_state = S_PLAY;
              nxt_digit = 2'd0;
            end else begin
              nxt_digit = digit - 2'd1;
            end
          end else begin
            nxt_fcnt = fcnt + 1'b1;
          end
        end
        S_PLAY: begin
          // game_over outranks a pause raised in the same frame
          if (ev_over) begin
            nxt_state = S_OVER;
            nxt_fcnt  = '0;
          end else if (ev_pause) begin
            nxt_state = S_PAUSE;
          end
        end
        S_PAUSE: begin
          // resume goes straight back to play, no countdown
          if (ev_start || ev_pause) nxt_state = S_PLAY;
        end
        S_OVER: begin
          if (fcnt == OVER_LAST) begin
            nxt_state = S_MENU;
            nxt_fcnt  = '0;
          end else begin
            nxt_fcnt = fcnt + 1'b1;
          end
        end
        default: begin
          nxt_state = S_MENU;
          nxt_fcnt  = '0;
          nxt_digit = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_MENU;
      fcnt  <= '0;
      digit <= 2'd0;
    end else begin
      state <= nxt_state;
      fcnt  <= nxt_fcnt;
      digit <= nxt_digit;
    end
  end

  // Outputs decoded from the next state so they land together with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_game_on <= 1'b0;
      menu_id    <= MENU_MAIN;
      countdown  <= 2'd0;
      game_reset <= 1'b0;
    end else begin
      is_game_on <= (nxt_state == S_PLAY);
      menu_id    <= menu_of(nxt_state);
      countdown  <= (nxt_state == S_COUNTDOWN) ? nxt_digit : 2'd0;
      game_reset <= new_game;
    end
  end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl with a short countdown (3 digits x 2
// frames) and a 4-frame game-over hold. Inputs change on the falling edge,
// outputs are sampled on the falling edge after the committing rising edge.
module tb_game_state_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       vblnk;
  logic       start, pause, game_over;
  logic       is_game_on;
  logic [1:0] menu_id;
  logic [1:0] countdown;
  logic       game_reset;

  int n_cmp = 0;
  int n_err = 0;

  game_state_ctrl #(
    .COUNTDOWN_START  (3),
    .COUNTDOWN_FRAMES (2),
    .OVER_HOLD_FRAMES (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vblnk      (vblnk),
    .start      (start),
    .pause      (pause),
    .game_over  (game_over),
    .is_game_on (is_game_on),
    .menu_id    (menu_id),
    .countdown  (countdown),
    .game_reset (game_reset)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic on, input logic [1:0] menu,
                           input logic [1:0] cd, input logic gr);
    check({tag, ".on"},   {7'd0, is_game_on}, {7'd0, on});
    check({tag, ".menu"}, {6'd0, menu_id},    {6'd0, menu});
    check({tag, ".cd"},   {6'd0, countdown},  {6'd0, cd});
    check({tag, ".gr"},   {7'd0, game_reset}, {7'd0, gr});
  endtask

  // One frame start; returns at the falling edge after the commit edge.
  task automatic frame;
    @(negedge clk) vblnk = 1'b0;
    @(negedge clk) vblnk = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic pulse_pause;
    @(negedge clk) pause = 1'b1;
    @(negedge clk) pause = 1'b0;
  endtask

  task automatic pulse_over;
    @(negedge clk) game_over = 1'b1;
    @(negedge clk) game_over = 1'b0;
  endtask

  initial begin
    rst = 1'b1; vblnk = 1'b1; start = 1'b0; pause = 1'b0; game_over = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    // 1: reset state, vblnk held high gives no tick
    check_all("reset", 1'b0, 2'd1, 2'd0, 1'b0);
    repeat (3) @(negedge clk);
    check_all("reset_hold", 1'b0, 2'd1, 2'd0, 1'b0);

    // 2: start mid-frame waits for the tick, then countdown 3,2,1 -> play
    pulse_start();
    @(negedge clk);
    check_all("start_wait", 1'b0, 2'd1, 2'd0, 1'b0);
    frame();
    check_all("cd3", 1'b0, 2'd0, 2'd3, 1'b1);
    @(negedge clk);
    check("cd3_gr_drop", {7'd0, game_reset}, 8'd0);
    frame();
    check_all("cd3b", 1'b0, 2'd0, 2'd3, 1'b0);
    frame();
    check_all("cd2", 1'b0, 2'd0, 2'd2, 1'b0);
    frame(); frame();
    check_all("cd1", 1'b0, 2'd0, 2'd1, 1'b0);
    frame();
    check_all("cd1b", 1'b0, 2'd0, 2'd1, 1'b0);
    frame();
    check_all("play", 1'b1, 2'd0, 2'd0, 1'b0);

    // 3: pause and resume
    pulse_pause();
    @(negedge clk);
    check_all("pause_wait", 1'b1, 2'd0, 2'd0, 1'b0);
    frame();
    check_all("paused", 1'b0, 2'd2, 2'd0, 1'b0);
    frame();
    check_all("paused_hold", 1'b0, 2'd2, 2'd0, 1'b0);
    pulse_start();
    frame();
    check_all("resumed", 1'b1, 2'd0, 2'd0, 1'b0);

    // 4: pause + game_over in one frame -> over; start during hold ignored
    pulse_pause();
    pulse_over();
    frame();
    check_all("over", 1'b0, 2'd3, 2'd0, 1'b0);
    frame();
    pulse_start();
    frame(); frame();
    check_all("over_hold", 1'b0, 2'd3, 2'd0, 1'b0);
    frame();
    check_all("over_done", 1'b0, 2'd1, 2'd0, 1'b0);
    frame();
    check_all("menu_stay", 1'b0, 2'd1, 2'd0, 1'b0);

    // 5: start pulse in the tick cycle itself is acted on
    @(negedge clk) vblnk = 1'b0;
    @(negedge clk) begin vblnk = 1'b1; start = 1'b1; end
    @(negedge clk) start = 1'b0;
    check_all("start_at_tick", 1'b0, 2'd0, 2'd3, 1'b1);

    // 6: reset in countdown digit 2 with a start pending
    frame(); frame();
    check_all("cd2_again", 1'b0, 2'd0, 2'd2, 1'b0);
    pulse_start();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check_all("mid_reset", 1'b0, 2'd1, 2'd0, 1'b0);
    frame(); frame();
    check_all("post_reset", 1'b0, 2'd1, 2'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
